// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the memory-port arbiter slice.
package cpu_mem_pkg;

  // Owner tag stored per in-flight read so the response can be routed back.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int OUTSTANDING_DEF = 4;
  localparam int MAX_WAIT_DEF    = 3;

endpackage

// File: rtl/owner_fifo.sv
// Small tag FIFO: remembers which requester issued each outstanding read.
// Depth must be a power of two so the pointers wrap naturally.
module owner_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_cnt;
  logic                    w_push;
  logic                    w_pop;

  // A pop frees a slot in the same cycle, so a push at full is legal then.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));
  assign dout  = r_mem[r_rptr];
  assign count = r_cnt;

  // Tag storage; contents are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers and occupancy; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a saturating wait counter forces a fetch grant after
// MAX_WAIT consecutive lost cycles. In-order read responses are routed back
// using a tag FIFO of owners.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter  int OUTSTANDING = OUTSTANDING_DEF,
  parameter  int MAX_WAIT    = MAX_WAIT_DEF,
  localparam int CW          = $clog2(OUTSTANDING) + 1
) (
  input  logic          clk,
  input  logic          rst,
  // fetch requester
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  // data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  // memory side
  output logic          m_req,
  output logic          m_we,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata,
  // status
  output logic          err,
  output logic [CW-1:0] inflight
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] r_wait;
  logic       r_err;

  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_pop;
  logic       w_push;
  owner_e     w_push_own;
  logic       w_rd_ok;
  logic       w_i_elig;
  logic       w_d_elig;
  logic       w_i_win;
  logic       w_d_win;

  // A response pops only if a tag exists; a stray one is flagged instead.
  assign w_pop = m_rvalid & ~w_empty & ~rst;

  // Reads need a free tag slot, counting the one freed by this cycle's pop.
  assign w_rd_ok  = ~w_full | w_pop;
  assign w_i_elig = i_req & w_rd_ok;
  assign w_d_elig = d_req & (d_we | w_rd_ok);

  // Fetch takes over once it has waited long enough, or when data is idle.
  assign w_i_win = ~rst & w_i_elig & ((r_wait == WAIT_MAX) | ~w_d_elig);
  assign w_d_win = ~rst & w_d_elig & ~w_i_win;

  assign m_req   = w_i_win | w_d_win;
  assign m_we    = w_d_win & d_we;
  assign m_addr  = w_i_win ? i_addr : d_addr;
  assign m_wdata = w_d_win ? d_wdata : 32'h0;

  assign i_gnt = w_i_win & m_ready;
  assign d_gnt = w_d_win & m_ready;

  // Only reads leave a tag behind; stores complete on grant.
  assign w_push     = i_gnt | (d_gnt & ~d_we);
  assign w_push_own = i_gnt ? OWN_I : OWN_D;

  owner_fifo #(
    .DEPTH (OUTSTANDING),
    .W     (1)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_push_own),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (inflight)
  );

  assign i_rvalid = w_pop & (owner_e'(w_head) == OWN_I);
  assign d_rvalid = w_pop & (owner_e'(w_head) == OWN_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign err      = r_err;

  // Count consecutive cycles fetch is left waiting, including memory stalls.
  always_ff @(posedge clk) begin
    if (rst)                 r_wait <= '0;
    else if (!i_req || i_gnt) r_wait <= '0;
    else if (r_wait != WAIT_MAX) r_wait <= r_wait + 4'd1;
  end

  // Sticky flag for a response that no outstanding read accounts for.
  always_ff @(posedge clk) begin
    if (rst)                      r_err <= 1'b0;
    else if (m_rvalid && w_empty) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus a random
// phase, checked every cycle against a queue-based reference model.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int OUT = 4;
  localparam int MW  = 3;
  localparam int CW  = $clog2(OUT) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [31:0]   i_addr, i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          m_req, m_we, m_ready, m_rvalid;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic          err;
  logic [CW-1:0] inflight;

  always #5 clk = ~clk;

  mem_port_arbiter #(.OUTSTANDING(OUT), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err), .inflight(inflight)
  );

  // expected read responses, in issue order (own: 0 = fetch, 1 = data)
  typedef struct { logic own; logic [31:0] data; } exp_t;
  exp_t sb[$];
  // memory model's pending responses
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t mq[$];

  int    n_cmp = 0, n_bad = 0, cyc = 0;
  int    lat = 1, last_due = 0, mwait = 0, first_rv = -1;
  bit    merr = 0, rnd_ready = 0, rnd_lat = 0, spur = 0, gnt_rv = 0;
  string glog = "";

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: in-order responses after the chosen latency
  initial begin
    m_rvalid = 1'b0; m_rdata = '0; m_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (spur) begin
        m_rvalid = 1'b1;
        spur     = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        m_rvalid = 1'b1;
        m_rdata  = mq[0].data;
        void'(mq.pop_front());
      end
    end
  end

  // monitor + reference model, evaluated mid-cycle
  initial begin : monitor
    bit pop, rd_ok, d_el, i_el, gnt;
    int ew, dd;
    forever begin
      @(negedge clk);
      pop   = m_rvalid && sb.size() > 0;
      rd_ok = (sb.size() < OUT) || pop;
      d_el  = d_req && (d_we || rd_ok);
      i_el  = i_req && rd_ok;
      if (rst)                                 ew = 0;
      else if (i_el && (mwait == MW || !d_el)) ew = 1;
      else if (d_el)                           ew = 2;
      else                                     ew = 0;
      gnt = (ew != 0) && m_ready;

      chk("m_req", m_req, ew != 0);
      chk("i_gnt", i_gnt, ew == 1 && m_ready);
      chk("d_gnt", d_gnt, ew == 2 && m_ready);
      if (ew == 1) begin
        chk("m_addr_fetch", m_addr, i_addr);
        chk("m_we_fetch", m_we, 0);
        chk("m_wdata_fetch", m_wdata, 0);
      end
      if (ew == 2) begin
        chk("m_addr_data", m_addr, d_addr);
        chk("m_we_data", m_we, d_we);
        if (d_we) chk("m_wdata_data", m_wdata, d_wdata);
      end
      chk("i_rvalid", i_rvalid, !rst && pop && sb[0].own == 1'b0);
      chk("d_rvalid", d_rvalid, !rst && pop && sb[0].own == 1'b1);
      if (!rst && pop) begin
        if (sb[0].own) chk("d_rdata", d_rdata, sb[0].data);
        else           chk("i_rdata", i_rdata, sb[0].data);
      end
      chk("err", err, merr);
      chk("inflight", inflight, sb.size());

      if (rst) begin
        sb.delete(); mq.delete();
        mwait = 0; merr = 0; last_due = 0;
      end else begin
        if (m_rvalid && sb.size() == 0) merr = 1;
        if (m_rvalid && first_rv < 0) first_rv = cyc;
        if (pop) void'(sb.pop_front());
        if (gnt) begin
          if (ew == 1) glog = {glog, "I"};
          else         glog = {glog, "D"};
          gnt_rv = m_rvalid;
          if (ew == 1 || !d_we) begin
            sb.push_back('{own: (ew == 2), data: memfn(ew == 1 ? i_addr : d_addr)});
            dd = cyc + (rnd_lat ? int'($urandom_range(1, 6)) : lat);
            if (dd <= last_due) dd = last_due + 1;
            last_due = dd;
            mq.push_back('{due: dd, data: memfn(m_addr)});
          end
        end
        if (!i_req || (ew == 1 && m_ready)) mwait = 0;
        else if (mwait < MW)                mwait++;
      end
    end
  end

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd, output int gc);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; gc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_gnt) begin gc = cyc; break; end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("d_gnt_within_bound", gc >= 0, 1);
  endtask

  task automatic req_i(input logic [31:0] a, output int gc);
    i_req = 1'b1; i_addr = a; gc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_gnt) begin gc = cyc; break; end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    chk("i_gnt_within_bound", gc >= 0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  gc, ic;
    bit  ig, dg, got;
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    // reset forces everything off even with requests and a response present
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80; spur = 1;
    repeat (2) @(posedge clk); #1;
    i_req = 0; d_req = 0; rst = 0;
    @(posedge clk); #1;

    // contention: both requesting, latency 1
    lat = 1; glog = "";
    i_req = 1; i_addr = 32'h0000_0100; d_req = 1; d_we = 0; d_addr = 32'h0000_0200;
    repeat (4) begin
      @(negedge clk); ig = i_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (dg) d_addr = d_addr + 32'd4;
      if (ig) i_req = 0;
    end
    i_req = 0; d_req = 0;
    chks("contention_order", glog, "DDDI");
    repeat (4) @(posedge clk); #1;

    // back-pressure: five stalled cycles, then fetch goes first
    glog = ""; m_ready = 0;
    i_req = 1; i_addr = 32'h0000_0300; d_req = 1; d_we = 0; d_addr = 32'h0000_0400;
    repeat (5) @(posedge clk); #1;
    chks("stall_no_grant", glog, "");
    m_ready = 1;
    @(posedge clk); #1; i_req = 0;
    @(posedge clk); #1; d_req = 0;
    chks("backpressure_order", glog, "ID");
    repeat (4) @(posedge clk); #1;

    // FIFO full with latency 8
    lat = 8; first_rv = -1;
    for (int k = 0; k < 4; k++) req_d(1'b0, 32'h1000 + 32'(k * 4), 32'h0, gc);
    chk("full_inflight", inflight, 4);
    ic = cyc;
    req_d(1'b1, 32'h2000, 32'hCAFE_F00D, gc);
    chk("store_at_full_immediate", gc, ic);
    req_d(1'b0, 32'h1010, 32'h0, gc);
    chk("load5_waits_first_rvalid", gc, first_rv);
    req_d(1'b0, 32'h1014, 32'h0, gc);
    // fetch at full, granted in the cycle a response frees a slot
    req_i(32'h3000, gc);
    chk("fetch_gnt_with_rvalid", gnt_rv, 1);
    chk("push_pop_inflight", inflight, 4);
    repeat (40) @(posedge clk); #1;

    // spurious response
    chk("idle_inflight", inflight, 0);
    spur = 1;
    repeat (3) @(posedge clk); #1;
    chk("err_set", err, 1);
    repeat (3) @(posedge clk); #1;
    chk("err_sticky", err, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("err_cleared_by_rst", err, 0);

    // reset with two reads in flight
    lat = 8;
    req_d(1'b0, 32'h5000, 32'h0, gc);
    req_d(1'b0, 32'h5004, 32'h0, gc);
    chk("two_inflight", inflight, 2);
    rst = 1; i_req = 1; i_addr = 32'h6000; d_req = 1; d_we = 0; d_addr = 32'h6004;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    @(posedge clk); #1;
    rst = 0; i_req = 0; d_req = 0;
    chk("rst_inflight", inflight, 0);
    lat = 2;
    req_d(1'b0, 32'hDEAD_BEEF ^ 32'h1234_5678, 32'h0, gc);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_rvalid) begin
        got = 1;
        chk("rst_roundtrip_data", d_rdata, 32'hDEAD_BEEF);
        break;
      end
    end
    chk("rst_roundtrip_seen", got, 1);
    @(posedge clk); #1;
    chk("rst_roundtrip_err", err, 0);

    // random traffic with stalls, variable latency and occasional reset
    rnd_ready = 1; rnd_lat = 1;
    repeat (3000) begin
      @(negedge clk); ig = i_gnt; dg = d_gnt;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 499) == 0);
      if (!i_req || ig) begin
        i_req  = $urandom_range(0, 1);
        i_addr = $urandom;
      end
      if (!d_req || dg) begin
        d_req   = $urandom_range(0, 1);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    rst = 0; i_req = 0; d_req = 0; rnd_ready = 0; rnd_lat = 0; m_ready = 1;
    repeat (40) @(posedge clk); #1;
    chk("final_inflight", inflight, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the instruction-fetch requester (IF stage PC) and the data requester (MEM stage load/store). Data accesses win by default. A wait counter guarantees that fetch is never starved. Read responses return in order, and a tag FIFO routes each one back to the requester that issued it. The block sits between the pipeline core and the memory model, replacing the direct dual-port hookup.

## Interface
- OUTSTANDING, 4: maximum in-flight reads (tag FIFO depth), power of two, 2..16
- MAX_WAIT, 3: consecutive lost cycles after which fetch takes priority, 1..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch read request, held with i_addr stable until i_gnt
- i_addr  in  32  fetch word address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request, held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data word address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_ready  in  1  memory accepts the request this cycle
- m_rvalid  in  1  read response valid, in order, latency ≥1 cycle
- m_rdata  in  32  read response data
- err  out  1  sticky: m_rvalid arrived with the tag FIFO empty
- inflight  out  $clog2(OUTSTANDING)+1  current read count in flight

## Operation
- **Eligibility:**
  - A read is eligible only if inflight < OUTSTANDING.
  - A store is always eligible.
- **Priority:**
  - Data wins by default.
  - Fetch wins when wait_cnt == MAX_WAIT.
  - An ineligible requester never wins.
- **Grant:**
  - Assert m_req for the winner and drive m_we/m_addr/m_wdata from it. Fetch always drives m_we=0 and m_wdata=0.
  - Assert winner_gnt = m_req & m_ready.
  - At most one gnt is asserted per cycle.
- **Tag FIFO** (owner per accepted read):
  - Push OWN_I or OWN_D on each granted read. Stores push nothing.
  - Pop on m_rvalid.
  - A push and a pop in the same cycle leaves inflight unchanged.
- **Response routing:**
  - i_rvalid = m_rvalid & head==OWN_I; d_rvalid = m_rvalid & head==OWN_D.
  - i_rdata and d_rdata both pass m_rdata through unconditionally.
- **wait_cnt (saturating):**
  - Increments when i_req & !i_gnt.
  - Clears on i_gnt or when i_req==0.
  - Saturates at MAX_WAIT.
- **Error case:** m_rvalid with an empty FIFO sets err. Nothing is popped and neither rvalid asserts. err clears only on rst.
- **Memory stall:** when m_ready==0, no gnt is asserted, m_req stays high for the current winner, and wait_cnt still advances.

## Timing
- Arbitration is combinational: the request is asserted and granted in the same cycle when m_ready=1. This adds no latency over the memory port.
- Response routing is combinational, in the same cycle as m_rvalid.
- FIFO pointers, inflight, wait_cnt and err update on posedge clk.
- **Reset state:**
  - rst=1 forces m_req, i_gnt and d_gnt to 0, regardless of inputs.
  - rst=1 also forces i_rvalid and d_rvalid to 0.
  - On reset the FIFO empties, inflight=0, wait_cnt=0 and err=0.
- **Reset mid-operation:** outstanding tags are dropped. A response arriving after reset release with the FIFO empty sets err.
- **Full FIFO with a response pending:** a read may still be granted in a cycle where inflight==OUTSTANDING and m_rvalid=1 (the pop frees the slot).

## Structure
- Package cpu_mem_pkg holds:
  - owner_e enum {OWN_I=1'b0, OWN_D=1'b1}
  - the OUTSTANDING and MAX_WAIT defaults
- Sub-module owner_fifo (parameterised depth and 1-bit width; push/pop/full/empty/count) holds the tags.
- Arbitration and wait_cnt logic stay in the top module.

## Test plan
- **Contention:** memory latency 1, i_req and d_req (load) both held 1 for 4 cycles with m_ready=1.
  - Grants follow D,D,D,I (fetch wins when wait_cnt reaches 3).
  - Each response goes to the matching rvalid, in issue order.
- **Back-pressure:** m_ready=0 for 5 cycles with both requesting.
  - No gnt asserts.
  - wait_cnt saturates at 3.
  - On m_ready=1, i_gnt asserts first.
- **FIFO full:** memory latency 8, OUTSTANDING=4, six data loads.
  - The 5th load is held until the first m_rvalid.
  - A store issued while inflight==4 is granted immediately.
- **Same-cycle push and pop at full:** inflight=4, m_rvalid=1 and an i_req in the same cycle.
  - i_gnt=1 and inflight stays 4.
- **Spurious response:** m_rvalid=1 with no reads outstanding.
  - err=1, sticky.
  - i_rvalid=d_rvalid=0.
  - rst clears err.
- **Reset with reads in flight:** rst asserted with 2 reads in flight.
  - All outputs 0 during rst.
  - Afterwards inflight=0, and a normal load round-trip routes to d_rvalid with data 32'hDEADBEEF.
